// File: rtl/micro_op_sequencer.sv
// PDP-8 operate-group (opcode 7) executor: a fixed-latency IDLE->T1..T4->DONE sequencer
// that applies the microinstruction events in architectural order and owns the MQ register.
module micro_op_sequencer #(
   parameter int unsigned WORD_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [11:0]           i_reg_i,
   input  logic [WORD_WIDTH-1:0] ac_i,
   input  logic                  l_i,
   input  logic [WORD_WIDTH-1:0] sr_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [WORD_WIDTH-1:0] ac_o,
   output logic                  l_o,
   output logic [WORD_WIDTH-1:0] mq_o,
   output logic                  skip_o,
   output logic                  halt_o,
   output logic                  illegal_o,
   output logic                  micro_g1_o,
   output logic                  micro_g2_o,
   output logic                  micro_g3_o
);

   localparam int unsigned HALF = WORD_WIDTH / 2;

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StT1   = 3'd1;
   localparam logic [2:0] StT2   = 3'd2;
   localparam logic [2:0] StT3   = 3'd3;
   localparam logic [2:0] StT4   = 3'd4;
   localparam logic [2:0] StDone = 3'd5;

   logic [2:0]            state_q, state_d;
   logic [11:0]           ir_q, ir_d;
   logic [WORD_WIDTH-1:0] ac_q, ac_d;
   logic                  l_q, l_d;
   logic [WORD_WIDTH-1:0] mq_q, mq_d;
   logic                  skip_q, skip_d;
   logic                  halt_q, halt_d;

   logic [WORD_WIDTH-1:0] ac_out_q;
   logic                  l_out_q, skip_out_q;
   logic                  g1_q, g2_q, g3_q;

   // PDP-8 numbering: ib[0] is the instruction MSB.
   logic [0:11] ib;
   logic        is_op7, is_g1, is_g2, is_g3, cond;
   logic [WORD_WIDTH:0] link_ac, rot_r1, rot_r2, rot_l1, rot_l2, inc;

   assign ib     = ir_q;
   assign is_op7 = (ir_q[11:9] == 3'b111);
   assign is_g1  = is_op7 & ~ib[3];
   assign is_g2  = is_op7 & ib[3] & ~ib[11];
   assign is_g3  = is_op7 & ib[3] & ib[11];
   assign cond   = (ib[5] & ac_q[WORD_WIDTH-1]) | (ib[6] & (ac_q == '0)) | (ib[7] & l_q);

   assign link_ac = {l_q, ac_q};
   assign rot_r1  = {link_ac[0], link_ac[WORD_WIDTH:1]};
   assign rot_r2  = {rot_r1[0], rot_r1[WORD_WIDTH:1]};
   assign rot_l1  = {link_ac[WORD_WIDTH-1:0], link_ac[WORD_WIDTH]};
   assign rot_l2  = {rot_l1[WORD_WIDTH-1:0], rot_l1[WORD_WIDTH]};
   assign inc     = {1'b0, ac_q} + {{WORD_WIDTH{1'b0}}, 1'b1};

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      ac_d    = ac_q;
      l_d     = l_q;
      mq_d    = mq_q;
      skip_d  = skip_q;
      halt_d  = halt_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               ir_d    = i_reg_i;
               ac_d    = ac_i;
               l_d     = l_i;
               skip_d  = 1'b0;
               halt_d  = 1'b0;
               state_d = StT1;
            end
         end
         StT1: begin
            if (is_g1) begin
               if (ib[4]) ac_d = '0;
               if (ib[5]) l_d = 1'b0;
            end
            // Skip sense uses the AC before CLA is applied.
            if (is_g2) skip_d = ib[8] ? ~cond : cond;
            if ((is_g2 | is_g3) & ib[4] & is_g3) ac_d = '0;
            state_d = StT2;
         end
         StT2: begin
            if (is_g1) begin
               if (ib[6]) ac_d = ~ac_q;
               if (ib[7]) l_d = ~l_q;
            end
            if (is_g2 & ib[4]) ac_d = '0;
            if (is_g3) begin
               if (ib[5] & ib[7]) begin
                  ac_d = mq_q;
                  mq_d = ac_q;
               end else if (ib[5]) begin
                  ac_d = ac_q | mq_q;
               end else if (ib[7]) begin
                  mq_d = ac_q;
                  ac_d = '0;
               end
            end
            state_d = StT3;
         end
         StT3: begin
            if (is_g1 & ib[11]) begin
               ac_d = inc[WORD_WIDTH-1:0];
               if (inc[WORD_WIDTH]) l_d = ~l_q;
            end
            if (is_g2 & ib[9]) ac_d = ac_q | sr_i;
            state_d = StT4;
         end
         StT4: begin
            if (is_g1) begin
               if (ib[8] & ~ib[9]) begin
                  {l_d, ac_d} = ib[10] ? rot_r2 : rot_r1;
               end else if (ib[9] & ~ib[8]) begin
                  {l_d, ac_d} = ib[10] ? rot_l2 : rot_l1;
               end else if (ib[10] & ~ib[8] & ~ib[9]) begin
                  ac_d = {ac_q[HALF-1:0], ac_q[WORD_WIDTH-1:HALF]};
               end
            end
            if (is_g2) halt_d = ib[10];
            state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ir_q    <= '0;
         ac_q    <= '0;
         l_q     <= 1'b0;
         mq_q    <= '0;
         skip_q  <= 1'b0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         ac_q    <= ac_d;
         l_q     <= l_d;
         mq_q    <= mq_d;
         skip_q  <= skip_d;
         halt_q  <= halt_d;
      end
   end

   // Result registers load on the T4->DONE edge so they are valid alongside done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ac_out_q   <= '0;
         l_out_q    <= 1'b0;
         skip_out_q <= 1'b0;
         g1_q       <= 1'b0;
         g2_q       <= 1'b0;
         g3_q       <= 1'b0;
      end else if (state_q == StT4) begin
         ac_out_q   <= ac_d;
         l_out_q    <= l_d;
         skip_out_q <= skip_d;
         g1_q       <= is_g1;
         g2_q       <= is_g2;
         g3_q       <= is_g3;
      end
   end

   assign busy_o     = (state_q == StT1) | (state_q == StT2) | (state_q == StT3) |
                       (state_q == StT4);
   assign done_o     = (state_q == StDone);
   assign halt_o     = done_o & halt_q;
   assign illegal_o  = done_o & ~is_op7;
   assign ac_o       = ac_out_q;
   assign l_o        = l_out_q;
   assign mq_o       = mq_q;
   assign skip_o     = skip_out_q;
   assign micro_g1_o = g1_q;
   assign micro_g2_o = g2_q;
   assign micro_g3_o = g3_q;

endmodule

// File: tb/tb_micro_op_sequencer.sv
// Directed bench for micro_op_sequencer: octal vector table plus handshake/abort sequences.
module tb_micro_op_sequencer;

   localparam int unsigned W = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [11:0]   i_reg = '0;
   logic [W-1:0]  ac_in = '0;
   logic          l_in = 1'b0;
   logic [W-1:0]  sr = '0;
   logic          busy, done, l_out, skip, halt, illegal, g1, g2, g3;
   logic [W-1:0]  ac_out, mq_out;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;

   micro_op_sequencer #(.WORD_WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start),
      .i_reg_i    (i_reg),
      .ac_i       (ac_in),
      .l_i        (l_in),
      .sr_i       (sr),
      .busy_o     (busy),
      .done_o     (done),
      .ac_o       (ac_out),
      .l_o        (l_out),
      .mq_o       (mq_out),
      .skip_o     (skip),
      .halt_o     (halt),
      .illegal_o  (illegal),
      .micro_g1_o (g1),
      .micro_g2_o (g2),
      .micro_g3_o (g3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done) done_cnt++;

   typedef struct {
      logic [11:0]  ir;
      logic [W-1:0] ac;
      logic         l;
      logic [W-1:0] sr;
      logic [W-1:0] e_ac;
      logic         e_l;
      logic         e_skip;
      logic         e_halt;
      logic         e_ill;
      logic [2:0]   e_g;   // {g1,g2,g3}
      logic [W-1:0] e_mq;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0o expected %0o", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one instruction and wait (bounded) for done; returns edges from T1 to DONE.
   task automatic run_op(input logic [11:0] ir, input logic [W-1:0] ac, input logic l,
                         input logic [W-1:0] s, output int lat, output int nbusy);
      start = 1'b1;
      i_reg = ir;
      ac_in = ac;
      l_in  = l;
      sr    = s;
      step();
      start = 1'b0;
      lat   = 0;
      nbusy = 0;
      while (!done && lat < 10) begin
         if (busy) nbusy++;
         step();
         lat++;
      end
   endtask

   function automatic vec_t mk(input logic [11:0] ir, input logic [W-1:0] ac, input logic l,
                               input logic [W-1:0] s, input logic [W-1:0] e_ac,
                               input logic e_l, input logic e_skip, input logic e_halt,
                               input logic e_ill, input logic [2:0] e_g,
                               input logic [W-1:0] e_mq);
      vec_t v;
      v.ir = ir; v.ac = ac; v.l = l; v.sr = s; v.e_ac = e_ac; v.e_l = e_l;
      v.e_skip = e_skip; v.e_halt = e_halt; v.e_ill = e_ill; v.e_g = e_g; v.e_mq = e_mq;
      return v;
   endfunction

   initial begin
      int lat, nbusy, base;

      //              ir        ac        l     sr        e_ac      e_l  sk  ht  il  grp     mq
      vecs[0]  = mk(12'o7041, 12'o0005, 1'b0, 12'o0000, 12'o7773, 1'b0, 0, 0, 0, 3'b100, 12'o0);
      vecs[1]  = mk(12'o7001, 12'o7777, 1'b0, 12'o0000, 12'o0000, 1'b1, 0, 0, 0, 3'b100, 12'o0);
      vecs[2]  = mk(12'o7006, 12'o4001, 1'b0, 12'o0000, 12'o0005, 1'b0, 0, 0, 0, 3'b100, 12'o0);
      vecs[3]  = mk(12'o7002, 12'o0077, 1'b0, 12'o0000, 12'o7700, 1'b0, 0, 0, 0, 3'b100, 12'o0);
      vecs[4]  = mk(12'o7010, 12'o0001, 1'b0, 12'o0000, 12'o0000, 1'b1, 0, 0, 0, 3'b100, 12'o0);
      vecs[5]  = mk(12'o7004, 12'o4000, 1'b0, 12'o0000, 12'o0000, 1'b1, 0, 0, 0, 3'b100, 12'o0);
      vecs[6]  = mk(12'o7012, 12'o0003, 1'b0, 12'o0000, 12'o4000, 1'b1, 0, 0, 0, 3'b100, 12'o0);
      vecs[7]  = mk(12'o7120, 12'o0707, 1'b0, 12'o0000, 12'o0707, 1'b1, 0, 0, 0, 3'b100, 12'o0);
      vecs[8]  = mk(12'o7500, 12'o4000, 1'b0, 12'o0000, 12'o4000, 1'b0, 1, 0, 0, 3'b010, 12'o0);
      vecs[9]  = mk(12'o7510, 12'o4000, 1'b0, 12'o0000, 12'o4000, 1'b0, 0, 0, 0, 3'b010, 12'o0);
      vecs[10] = mk(12'o7410, 12'o0123, 1'b0, 12'o0000, 12'o0123, 1'b0, 1, 0, 0, 3'b010, 12'o0);
      vecs[11] = mk(12'o7640, 12'o1234, 1'b0, 12'o0000, 12'o0000, 1'b0, 0, 0, 0, 3'b010, 12'o0);
      vecs[12] = mk(12'o7402, 12'o0007, 1'b0, 12'o0000, 12'o0007, 1'b0, 0, 1, 0, 3'b010, 12'o0);
      vecs[13] = mk(12'o7404, 12'o0001, 1'b0, 12'o0100, 12'o0101, 1'b0, 0, 0, 0, 3'b010, 12'o0);
      vecs[14] = mk(12'o7420, 12'o0000, 1'b1, 12'o0000, 12'o0000, 1'b1, 1, 0, 0, 3'b010, 12'o0);
      vecs[15] = mk(12'o7421, 12'o1234, 1'b1, 12'o0000, 12'o0000, 1'b1, 0, 0, 0, 3'b001,
                    12'o1234);
      vecs[16] = mk(12'o7501, 12'o0070, 1'b0, 12'o0000, 12'o1274, 1'b0, 0, 0, 0, 3'b001,
                    12'o1234);
      vecs[17] = mk(12'o7521, 12'o5555, 1'b0, 12'o0000, 12'o1234, 1'b0, 0, 0, 0, 3'b001,
                    12'o5555);
      vecs[18] = mk(12'o1234, 12'o2222, 1'b1, 12'o0000, 12'o2222, 1'b1, 0, 0, 1, 3'b000,
                    12'o5555);
      vecs[19] = mk(12'o6402, 12'o0017, 1'b0, 12'o0000, 12'o0017, 1'b0, 0, 0, 1, 3'b000,
                    12'o5555);

      // Reset state
      repeat (3) step();
      rst_n = 1'b1;
      step();
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_ac", ac_out, 12'o0);
      check("reset_l", l_out, 1'b0);
      check("reset_mq", mq_out, 12'o0);
      check("reset_flags", {skip, halt, illegal, g1, g2, g3}, 6'b0);

      foreach (vecs[i]) begin
         run_op(vecs[i].ir, vecs[i].ac, vecs[i].l, vecs[i].sr, lat, nbusy);
         check($sformatf("v%0d_latency", i), lat, 4);
         check($sformatf("v%0d_busy_cycles", i), nbusy, 4);
         check($sformatf("v%0d_done_busy", i), busy, 1'b0);
         check($sformatf("v%0d_ac", i), ac_out, vecs[i].e_ac);
         check($sformatf("v%0d_l", i), l_out, vecs[i].e_l);
         check($sformatf("v%0d_skip", i), skip, vecs[i].e_skip);
         check($sformatf("v%0d_halt", i), halt, vecs[i].e_halt);
         check($sformatf("v%0d_illegal", i), illegal, vecs[i].e_ill);
         check($sformatf("v%0d_groups", i), {g1, g2, g3}, vecs[i].e_g);
         check($sformatf("v%0d_mq", i), mq_out, vecs[i].e_mq);
         step();
         check($sformatf("v%0d_done_pulse", i), {done, halt, illegal}, 3'b000);
         check($sformatf("v%0d_ac_held", i), ac_out, vecs[i].e_ac);
      end

      // Start during T2 and during DONE must be ignored
      base = done_cnt;
      start = 1'b1; i_reg = 12'o7041; ac_in = 12'o0005; l_in = 1'b0;
      step();                                   // T1
      start = 1'b0;
      step();                                   // T2
      start = 1'b1; i_reg = 12'o7001; ac_in = 12'o7777;
      step();                                   // T3
      start = 1'b0;
      check("ign_busy_t3", busy, 1'b1);
      step();                                   // T4
      step();                                   // DONE
      check("ign_done_at_n5", done, 1'b1);
      check("ign_ac", ac_out, 12'o7773);
      start = 1'b1; i_reg = 12'o7001;
      step();
      start = 1'b0;
      check("ign_start_in_done", busy, 1'b0);
      repeat (8) step();
      check("ign_single_done", done_cnt - base, 1);

      // Reset during T2 aborts with no done
      start = 1'b1; i_reg = 12'o7421; ac_in = 12'o0555; l_in = 1'b1;
      step();                                   // T1
      start = 1'b0;
      step();                                   // T2
      check("abort_mq_before", mq_out, 12'o5555);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_mq", mq_out, 12'o0);
      check("abort_outs", {done, ac_out, l_out, skip, g1, g2, g3}, '0);
      base = done_cnt;
      #3 rst_n = 1'b1;
      repeat (8) step();
      check("abort_no_done", done_cnt - base, 0);
      check("abort_idle", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
